// File: rtl/ntt_pointwise_mul_if.sv
// ----------------------------------------------------------------------------
// ntt_pointwise_mul_if
//   Bundles the coefficient stream coming from the forward NTT core and the
//   product stream leaving the pointwise multiplier.
//
//   Signals (all synchronous to the block clock):
//     in_valid  : coefficient strobe (NTT output_valid)
//     in_data   : 23-bit NTT-domain coefficient (NTT output_data)
//     clr       : synchronous abort back to the frame start
//     out_valid : result strobe
//     out_data  : 23-bit (a[i]*b[i]) mod Q
//     out_last  : marks the N-th result of a frame
//     phase     : 0 while collecting poly A, 1 while collecting poly B
//     err       : sticky range error, only when PWM_RANGE_CHECK_EN is defined
//
//   Modports: master drives the inputs and observes the results (source side),
//   slave is the multiplier itself.
// ----------------------------------------------------------------------------
interface ntt_pointwise_mul_if;
    logic        in_valid;
    logic [22:0] in_data;
    logic        clr;
    logic        out_valid;
    logic [22:0] out_data;
    logic        out_last;
    logic        phase;
`ifdef PWM_RANGE_CHECK_EN
    logic        err;
`endif

    modport master (
        output in_valid, in_data, clr,
`ifdef PWM_RANGE_CHECK_EN
        input  err,
`endif
        input  out_valid, out_data, out_last, phase
    );

    modport slave (
        input  in_valid, in_data, clr,
`ifdef PWM_RANGE_CHECK_EN
        output err,
`endif
        output out_valid, out_data, out_last, phase
    );
endinterface

// File: rtl/ntt_pointwise_mul.sv
// ----------------------------------------------------------------------------
// ntt_pointwise_mul
//   Captures two NTT-domain polynomials streamed back to back (A then B),
//   multiplies them coefficient by coefficient modulo Q = 8380417 and streams
//   the N products out through a two-register pipeline (product, reduction).
//   The input has no backpressure: one coefficient is accepted every cycle
//   in_valid is high.
//
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-high reset
//     bus : ntt_pointwise_mul_if.slave
//             in_valid/in_data/clr in, out_valid/out_data/out_last/phase out,
//             err out when PWM_RANGE_CHECK_EN is defined
//
//   Parameter N: coefficients per polynomial, power of two, 2..256.
//
//   Optional feature (macro PWM_RANGE_CHECK_EN): sticky err flag that sets
//   one cycle after any accepted in_data >= Q and clears on rst or clr.
// ----------------------------------------------------------------------------
module ntt_pointwise_mul #(
    parameter int N = 256
) (
    input  logic               clk,
    input  logic               rst,
    ntt_pointwise_mul_if.slave bus
);
    localparam int          CNT_W = $clog2(N);
    localparam logic [22:0] Q     = 23'd8380417;
    localparam logic [23:0] Q_EXT = {1'b0, Q};

    typedef enum logic {
        LOAD_A = 1'b0,
        MUL_B  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [22:0]      r_a_mem [N];

    logic [45:0]      r_prod;
    logic             r_v1;
    logic             r_last1;

    logic [22:0]      r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_accept;
    logic             w_cnt_end;
    logic             w_mul;
    logic [22:0]      w_a_op;
    logic [36:0]      w_t1;
    logic [27:0]      w_t2;
    logic [23:0]      w_t3;
    logic [22:0]      w_red;

    // clr wins over a simultaneous strobe: that coefficient is dropped.
    assign w_accept  = bus.in_valid & ~bus.clr;
    assign w_cnt_end = (r_cnt == CNT_W'(N - 1));
    assign w_mul     = w_accept & (r_state == MUL_B);
    assign w_a_op    = r_a_mem[r_cnt];

    // ------------------------------------------------------------------
    // Frame FSM: LOAD_A fills a_mem, MUL_B pairs each b with a_mem[cnt].
    // ------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order of statements and blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (bus.clr) begin
            r_state <= LOAD_A;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (bus.in_valid) begin
            if (w_cnt_end) begin
                r_cnt <= '0;
                if (r_state == LOAD_A) begin
                    r_state <= MUL_B;
                    r_phase <= 1'b1;
                end else begin
                    r_state <= LOAD_A;
                    r_phase <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // NOTE: the coefficient store has no reset; it is always fully written in
    // LOAD_A before MUL_B reads it, so reset logic would buy nothing.
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == LOAD_A)) begin
            r_a_mem[r_cnt] <= bus.in_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: full 46-bit product. The a operand is captured here, so a
    // following frame may overwrite a_mem while products are in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod  <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            r_v1    <= w_mul;
            r_last1 <= w_mul & w_cnt_end;
            if (w_mul) begin
                r_prod <= 46'(w_a_op) * 46'(bus.in_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reduction mod Q = 2^23 - 2^13 + 1, using 2^23 == 2^13 - 1 (mod Q).
    // Three folds shrink any 46-bit product below 2Q, then one conditional
    // subtract lands in [0, Q-1]. Exact for operands >= Q as well.
    //   t1 < 2^36 + 2^23, t2 < 2^28, t3 < 32*8191 + 2^23 < 2Q
    // ------------------------------------------------------------------
    assign w_t1  = {1'b0, r_prod[45:23], 13'd0}
                 - {14'd0, r_prod[45:23]}
                 + {14'd0, r_prod[22:0]};
    assign w_t2  = {1'b0, w_t1[36:23], 13'd0}
                 - {14'd0, w_t1[36:23]}
                 + {5'd0, w_t1[22:0]};
    assign w_t3  = {6'd0, w_t2[27:23], 13'd0}
                 - {19'd0, w_t2[27:23]}
                 + {1'b0, w_t2[22:0]};
    assign w_red = (w_t3 >= Q_EXT) ? 23'(w_t3 - Q_EXT) : w_t3[22:0];

    // Stage 2: reduced result. out_data holds between valid results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (bus.clr) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            r_out_last  <= r_v1 & r_last1;
            if (r_v1) begin
                r_out_data <= w_red;
            end
        end
    end

`ifdef PWM_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.clr) begin
            r_err <= 1'b0;
        end else if (bus.in_valid && (bus.in_data >= Q)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.phase     = r_phase;
endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// ----------------------------------------------------------------------------
// tb_ntt_pointwise_mul
//   Scoreboard bench for ntt_pointwise_mul. Every B coefficient driven pushes
//   its expected product, last flag and due cycle; the output monitor pops and
//   compares on each out_valid. Inputs change 1 time unit after the rising
//   edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ntt_pointwise_mul;
    localparam int          N = 256;
    localparam logic [22:0] Q = 23'd8380417;

    typedef struct {
        logic [22:0] data;
        logic        last;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    ntt_pointwise_mul_if bus ();

    ntt_pointwise_mul #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        exp_q[$];
    logic [22:0] a_m [N];
    int          cnt_m   = 0;
    bit          phase_m = 1'b0;
    logic [22:0] va [N];
    logic [22:0] vb [N];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        check("out_last_gated", 64'(bus.out_last & ~bus.out_valid), 64'd0);
        if (bus.out_valid === 1'b1) begin
            check("out_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e.data));
                check("out_last", 64'(bus.out_last), 64'(e.last));
                check("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Drive one accepted coefficient and update the reference model.
    task automatic put(input logic [22:0] d);
        exp_t            e;
        longint unsigned p;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.clr      = 1'b0;
        if (!phase_m) begin
            a_m[cnt_m] = d;
        end else begin
            p      = longint'(a_m[cnt_m]) * longint'(d);
            e.data = 23'(p % longint'(Q));
            e.last = (cnt_m == N - 1);
            e.due  = cyc + 2;  // product edge, then result edge
            exp_q.push_back(e);
        end
        if (cnt_m == N - 1) begin
            cnt_m   = 0;
            phase_m = ~phase_m;
        end else begin
            cnt_m++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse clr for one cycle, optionally with a (dropped) coefficient.
    task automatic pulse_clr(input logic v, input logic [22:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clr      = 1'b1;
        // Results due after this edge are discarded by the block.
        while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        cnt_m   = 0;
        phase_m = 1'b0;
        @(posedge clk);
        #1;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap_max);
        for (int i = 0; i < N; i++) begin
            if (gap_max > 0 && $urandom_range(1, 0) == 1) idle($urandom_range(gap_max, 1));
            put(va[i]);
        end
        check("phase_after_a", 64'(bus.phase), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (gap_max > 0 && $urandom_range(1, 0) == 1) idle($urandom_range(gap_max, 1));
            put(vb[i]);
        end
        check("phase_after_b", 64'(bus.phase), 64'd0);
    endtask

    task automatic rand_lt_q();
        for (int i = 0; i < N; i++) begin
            va[i] = 23'($urandom_range(int'(Q) - 1, 0));
            vb[i] = 23'($urandom_range(int'(Q) - 1, 0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d results pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clr      = 1'b0;
        rst          = 1'b1;
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_phase", 64'(bus.phase), 64'd0);
`ifdef PWM_RANGE_CHECK_EN
        check("rst_err", 64'(bus.err), 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A = 1, B = i -> 0..255, last only with 255.
        for (int i = 0; i < N; i++) begin
            va[i] = 23'd1;
            vb[i] = 23'(i);
        end
        run_frame(0);

        // Two frames back to back: (Q-1)^2 -> 1, then 2^22 * 2 -> 8191.
        for (int i = 0; i < N; i++) begin
            va[i] = Q - 23'd1;
            vb[i] = Q - 23'd1;
        end
        run_frame(0);
        for (int i = 0; i < N; i++) begin
            va[i] = 23'd4194304;
            vb[i] = 23'd2;
        end
        run_frame(0);

        // Random operands with random strobe gaps.
        rand_lt_q();
        run_frame(3);
        idle(4);
`ifdef PWM_RANGE_CHECK_EN
        check("err_in_range", 64'(bus.err), 64'd0);
`endif

        // clr together with the 100th B coefficient.
        rand_lt_q();
        for (int i = 0; i < N; i++) put(va[i]);
        for (int i = 0; i < 99; i++) put(vb[i]);
        pulse_clr(1'b1, vb[99]);
        check("clr_phase", 64'(bus.phase), 64'd0);
        check("clr_out_valid", 64'(bus.out_valid), 64'd0);
        idle(6);
        rand_lt_q();
        run_frame(0);

        // Full 23-bit operands, including values >= Q.
        for (int i = 0; i < N; i++) begin
            va[i] = 23'($urandom());
            vb[i] = 23'($urandom());
        end
        va[0] = Q;
        vb[5] = Q;
        vb[6] = 23'h7FFFFF;
        put(va[0]);
`ifdef PWM_RANGE_CHECK_EN
        check("err_set", 64'(bus.err), 64'd1);
`endif
        for (int i = 1; i < N; i++) put(va[i]);
        for (int i = 0; i < N; i++) put(vb[i]);
        idle(4);
`ifdef PWM_RANGE_CHECK_EN
        check("err_sticky", 64'(bus.err), 64'd1);
`endif
        pulse_clr(1'b0, '0);
`ifdef PWM_RANGE_CHECK_EN
        check("err_cleared", 64'(bus.err), 64'd0);
`endif

        // Asynchronous reset in the middle of the B phase.
        rand_lt_q();
        for (int i = 0; i < N; i++) put(va[i]);
        for (int i = 0; i < 50; i++) put(vb[i]);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_out_data", 64'(bus.out_data), 64'd0);
        check("arst_out_last", 64'(bus.out_last), 64'd0);
        check("arst_phase", 64'(bus.phase), 64'd0);
        exp_q.delete();
        cnt_m   = 0;
        phase_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_lt_q();
        run_frame(2);

        // Drain: bounded wait for all outstanding results.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        idle(2);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
